lcd_ctrl: RTL and testbench
===========================

Name: lcd_ctrl

Overview:
- Controller for an 8x8 grayscale image (64 bytes, 8 bits per pixel) driving a 4x4 display window.
- Loads the image from a byte stream and executes one 3-bit command at a time: refresh, load, shift, zoom in, zoom out (fit).
- Emits the 16 displayed pixels as a stream after every command.
- Sits between a host command/data source and the LCD output stage; the host uses `busy` for handshake.

Parameters:
- DW, 8, pixel/data width
- IMG_W, 8, image width and height (64 pixels)
- WIN, 4, display window width and height (16 output pixels)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- datain  input  8  image byte during load
- cmd  input  3  command code, valid with cmd_valid
- cmd_valid  input  1  command strobe, one cycle
- dataout  output  8  displayed pixel
- output_valid  output  1  dataout is valid this cycle
- busy  output  1  command in progress; cmd_valid is ignored while high

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Reset sets:
  - dataout=0, output_valid=0, busy=0
  - mode=FIT, window origin (row,col)=(2,2)
  - image memory is not cleared.
- A command is accepted on a rising edge with cmd_valid=1 and busy=0. busy is registered high on that same edge.
- Command codes:
  - 0 REFLASH: no state change.
  - 1 LOAD: capture the next 64 datain bytes, one per cycle, starting the cycle after acceptance. Store in raster order (address = row*8+col). Then mode=FIT, origin=(2,2).
  - 2 SHIFT_RIGHT: col+1 if col<4.
  - 3 SHIFT_LEFT: col-1 if col>0.
  - 4 SHIFT_UP: row-1 if row>0.
  - 5 SHIFT_DOWN: row+1 if row<4.
  - 6 ZOOM_IN: if mode is FIT, set mode=ZOOM and origin=(2,2) (window rows/cols 2..5). If already ZOOM, no change.
  - 7 ZOOM_OUT: mode=FIT. The origin is reset to (2,2) at the next ZOOM_IN.
- All shifts are no-ops in FIT mode. A shift at a boundary leaves the origin unchanged.
- Every command, including LOAD and no-op cases, produces exactly 16 output cycles.
- Output timing:
  - Non-LOAD: output_valid is high for 16 consecutive cycles, starting the first cycle after acceptance.
  - LOAD: output_valid is high for 16 consecutive cycles, starting the cycle after the 64th byte is captured. busy stays high throughout the load.
  - busy and output_valid fall on the same edge, after the 16th pixel. The next command may be accepted on the following edge.
- Output order is row-major within the window:
  - ZOOM: pixel (row+i, col+j) for i,j = 0..3.
  - FIT: pixels at rows {1,3,5,7} x cols {1,3,5,7}, i.e. addresses 9,11,13,15,25,...,63.
- cmd and datain are don't-care (may be X/Z) when not being sampled. cmd_valid while busy is dropped, not queued.
- Reset mid-command aborts the command immediately. Bytes already captured remain in memory.

Decomposition:
- Package lcd_ctrl_pkg holds:
  - command enum (REFLASH, LOAD, SHIFT_R/L/U/D, ZOOM_IN, ZOOM_OUT)
  - mode enum (FIT, ZOOM)
  - FSM state enum (IDLE, LOAD, OUTPUT)
  - constants IMG_W=8, WIN=4, ORIGIN_MAX=4, ORIGIN_INIT=2
- One sub-module, lcd_img_mem: 64x8 register array with synchronous write and combinational read.
- The top level contains the FSM, origin registers, 6-bit load counter and 4-bit output counter.
- Address generation:
  - ZOOM: {row+i, col+j}
  - FIT: {2i+1, 2j+1}

Test Plan:
- Fill the image with pixel[k]=k. LOAD -> after 64 bytes, 16 outputs 09,0B,0D,0F,19,1B,1D,1F,29,2B,2D,2F,39,3B,3D,3F. busy stays high until the last output.
- ZOOM_IN -> 12,13,14,15,1A,1B,1C,1D,22,23,24,25,2A,2B,2C,2D. output_valid starts the cycle after acceptance.
- From (2,2): SHIFT_RIGHT x3 -> windows start 13, 14, 14 (column saturates at 4). Then SHIFT_UP x3 -> windows start 0C, 04, 04.
- ZOOM_OUT, then SHIFT_DOWN and REFLASH -> each outputs the FIT list unchanged. Then ZOOM_IN -> window starts at 12 again.
- Pulse cmd_valid with SHIFT_LEFT while busy -> ignored; exactly 16 outputs for the original command.
- Assert reset during the LOAD byte stream -> next cycle busy=0, output_valid=0, dataout=0. A fresh LOAD then completes normally.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the 8x8 image / 4x4 window LCD controller.
// Includes the window-pixel address helper used by the top-level read path.
package lcd_ctrl_pkg;

    localparam int DW          = 8;
    localparam int IMG_W       = 8;
    localparam int WIN         = 4;
    localparam int AW          = 6;
    localparam logic [2:0] ORIGIN_MAX  = 3'd4;
    localparam logic [2:0] ORIGIN_INIT = 3'd2;

    typedef enum logic [2:0] {
        CMD_REFLASH  = 3'd0,
        CMD_LOAD     = 3'd1,
        CMD_SHIFT_R  = 3'd2,
        CMD_SHIFT_L  = 3'd3,
        CMD_SHIFT_U  = 3'd4,
        CMD_SHIFT_D  = 3'd5,
        CMD_ZOOM_IN  = 3'd6,
        CMD_ZOOM_OUT = 3'd7
    } cmd_e;

    typedef enum logic {
        MODE_FIT  = 1'b0,
        MODE_ZOOM = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_OUTPUT = 2'd2
    } state_e;

    // Raster address of window pixel idx (row-major within the 4x4 window).
    // FIT samples the odd rows/cols, so the address is just {i,1,j,1}.
    function automatic logic [AW-1:0] pix_addr(input mode_e mode, input logic [2:0] row,
                                               input logic [2:0] col, input logic [3:0] idx);
        logic [2:0] r;
        logic [2:0] c;
        if (mode == MODE_ZOOM) begin
            r = row + {1'b0, idx[3:2]};
            c = col + {1'b0, idx[1:0]};
        end else begin
            r = {idx[3:2], 1'b1};
            c = {idx[1:0], 1'b1};
        end
        return {r, c};
    endfunction

endpackage

// File: rtl/lcd_ctrl_img_mem.sv
// 64-byte image store: synchronous write, combinational read so the
// controller can register the selected pixel on the same edge it addresses it.
module lcd_img_mem #(
    parameter int DW    = 8,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DW-1:0]            rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lcd_ctrl.sv
// LCD window controller: loads an 8x8 image, applies one command at a time
// and streams the 16 pixels of the resulting 4x4 window.
module lcd_ctrl #(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int WIN   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datain,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);
    import lcd_ctrl_pkg::*;

    localparam int DEPTH = IMG_W * IMG_W;
    localparam int CW    = $clog2(WIN * WIN);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e        state_q;
    mode_e         mode_q, mode_d;
    logic [2:0]    row_q, row_d;
    logic [2:0]    col_q, col_d;
    logic [AW-1:0] load_cnt_q;
    logic [CW-1:0] out_cnt_q;
    logic [DW-1:0] dataout_q;
    logic          output_valid_q;
    logic          busy_q;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          mem_we;

    // Window state that the incoming command would produce; only committed on acceptance.
    always_comb begin
        mode_d = mode_q;
        row_d  = row_q;
        col_d  = col_q;
        case (cmd_e'(cmd))
            CMD_LOAD: begin
                mode_d = MODE_FIT;
                row_d  = ORIGIN_INIT;
                col_d  = ORIGIN_INIT;
            end
            CMD_SHIFT_R: if (mode_q == MODE_ZOOM && col_q < ORIGIN_MAX) col_d = col_q + 3'd1;
            CMD_SHIFT_L: if (mode_q == MODE_ZOOM && col_q > 3'd0)       col_d = col_q - 3'd1;
            CMD_SHIFT_U: if (mode_q == MODE_ZOOM && row_q > 3'd0)       row_d = row_q - 3'd1;
            CMD_SHIFT_D: if (mode_q == MODE_ZOOM && row_q < ORIGIN_MAX) row_d = row_q + 3'd1;
            CMD_ZOOM_IN: begin
                if (mode_q == MODE_FIT) begin
                    mode_d = MODE_ZOOM;
                    row_d  = ORIGIN_INIT;
                    col_d  = ORIGIN_INIT;
                end
            end
            CMD_ZOOM_OUT: mode_d = MODE_FIT;
            default: ;
        endcase
    end

    // In IDLE the first pixel is fetched with the post-command window so it can go out next cycle.
    always_comb begin
        if (state_q == ST_IDLE) begin
            raddr = pix_addr(mode_d, row_d, col_d, '0);
        end else begin
            raddr = pix_addr(mode_q, row_q, col_q, out_cnt_q);
        end
    end

    assign mem_we = (state_q == ST_LOAD) && !reset;

    lcd_img_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_img_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (load_cnt_q),
        .wdata_i (datain),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            mode_q         <= MODE_FIT;
            row_q          <= ORIGIN_INIT;
            col_q          <= ORIGIN_INIT;
            load_cnt_q     <= '0;
            out_cnt_q      <= '0;
            dataout_q      <= '0;
            output_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        mode_q     <= mode_d;
                        row_q      <= row_d;
                        col_q      <= col_d;
                        busy_q     <= 1'b1;
                        load_cnt_q <= '0;
                        if (cmd_e'(cmd) == CMD_LOAD) begin
                            out_cnt_q <= '0;
                            state_q   <= ST_LOAD;
                        end else begin
                            dataout_q      <= rdata;
                            output_valid_q <= 1'b1;
                            out_cnt_q      <= CW'(1);
                            state_q        <= ST_OUTPUT;
                        end
                    end
                end
                ST_LOAD: begin
                    load_cnt_q <= load_cnt_q + AW'(1);
                    if (load_cnt_q == LAST_ADDR) begin
                        dataout_q      <= rdata;
                        output_valid_q <= 1'b1;
                        out_cnt_q      <= CW'(1);
                        state_q        <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    // Counter wraps to zero once the 16th pixel has been issued.
                    if (out_cnt_q == '0) begin
                        dataout_q      <= '0;
                        output_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                        state_q        <= ST_IDLE;
                    end else begin
                        dataout_q <= rdata;
                        out_cnt_q <= out_cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dataout      = dataout_q;
    assign output_valid = output_valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: a behavioural window model pushes the 16
// expected pixels per command; each scenario task collects and compares them.
module tb_lcd_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] datain;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic [7:0] dataout;
    logic       output_valid;
    logic       busy;

    lcd_ctrl #(.DW(8), .IMG_W(8), .WIN(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .datain       (datain),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .dataout      (dataout),
        .output_valid (output_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int         nvec = 0;
    int         nerr = 0;
    logic [7:0] img [64];
    bit         m_zoom;
    int         m_row;
    int         m_col;
    logic [7:0] exp_q [$];
    bit         load_busy_ok;

    function automatic void model_cmd(input int c);
        case (c)
            1: begin m_zoom = 0; m_row = 2; m_col = 2; end
            2: if (m_zoom && m_col < 4) m_col = m_col + 1;
            3: if (m_zoom && m_col > 0) m_col = m_col - 1;
            4: if (m_zoom && m_row > 0) m_row = m_row - 1;
            5: if (m_zoom && m_row < 4) m_row = m_row + 1;
            6: if (!m_zoom) begin m_zoom = 1; m_row = 2; m_col = 2; end
            7: m_zoom = 0;
            default: ;
        endcase
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                exp_q.push_back(m_zoom ? img[(m_row + i) * 8 + m_col + j]
                                       : img[(2 * i + 1) * 8 + 2 * j + 1]);
    endfunction

    // Issues one command (plus the 64-byte stream for LOAD); returns at the
    // first negedge where the output stream is due to be running.
    task automatic send_cmd(input int c);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL busy_wait: busy=%b required 0 before cmd %0d", busy, c);
        end
        cmd       = 3'(c);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd       = 3'b000;
        if (c == 1) begin
            load_busy_ok = 1;
            for (int k = 0; k < 64; k++) begin
                datain = 8'(k);
                img[k] = 8'(k);
                if (busy !== 1'b1) load_busy_ok = 0;
                @(negedge clk);
            end
            datain = 8'h00;
        end
        model_cmd(c);
    endtask

    task automatic collect(output logic [7:0] got [$], output int lat, output bit busy_ok);
        int n = 0;
        got = {};
        lat = -1;
        busy_ok = 1;
        while (n < 200) begin
            if (output_valid) begin
                if (lat < 0) lat = n;
                got.push_back(dataout);
                if (busy !== 1'b1) busy_ok = 0;
            end else if (lat >= 0) begin
                if (busy !== 1'b0) busy_ok = 0;
                break;
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        nvec++;
        if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b required 0", busy); end
        nvec++;
        if (output_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b required 0", output_valid); end
        nvec++;
        if (dataout !== 8'h00) begin nerr++; $display("FAIL reset_dataout: got %h required 00", dataout); end
        reset = 1'b0;
        $display("reset: busy=%b valid=%b dataout=%h", busy, output_valid, dataout);
    endtask

    task automatic test_load();
        logic [7:0] got [$];
        logic [7:0] e, g;
        int lat;
        bit bok;
        send_cmd(1);
        collect(got, lat, bok);
        $display("load: %0d pixels, first=%h latency=%0d", got.size(), (got.size() > 0) ? got[0] : 8'h00, lat);
        nvec++;
        if (lat !== 0) begin nerr++; $display("FAIL load_latency: got %0d required 0", lat); end
        nvec++;
        if (!(load_busy_ok && bok)) begin nerr++; $display("FAIL load_busy: got stream=%b tail=%b required 1/1", load_busy_ok, bok); end
        nvec++;
        if (got.size() != 16) begin nerr++; $display("FAIL load_count: got %0d required 16", got.size()); end
        for (int k = 0; k < 16; k++) begin
            e = exp_q.pop_front();
            g = (got.size() > 0) ? got.pop_front() : 8'h00;
            nvec++;
            if (g !== e) begin nerr++; $display("FAIL load_pix%0d: got %h required %h", k, g, e); end
        end
    endtask

    task automatic test_zoom_in();
        logic [7:0] got [$];
        logic [7:0] e, g;
        int lat;
        bit bok;
        send_cmd(6);
        collect(got, lat, bok);
        $display("zoom_in: %0d pixels, first=%h latency=%0d", got.size(), (got.size() > 0) ? got[0] : 8'h00, lat);
        nvec++;
        if (lat !== 0 || !bok) begin nerr++; $display("FAIL zoom_timing: got lat=%0d busy_ok=%b required 0/1", lat, bok); end
        nvec++;
        if (got.size() != 16) begin nerr++; $display("FAIL zoom_count: got %0d required 16", got.size()); end
        for (int k = 0; k < 16; k++) begin
            e = exp_q.pop_front();
            g = (got.size() > 0) ? got.pop_front() : 8'h00;
            nvec++;
            if (g !== e) begin nerr++; $display("FAIL zoom_pix%0d: got %h required %h", k, g, e); end
        end
    endtask

    // Walks a command list; each entry also carries the expected first pixel as an absolute anchor.
    task automatic run_list_check(input string tag, input int cmds [], input logic [7:0] first []);
        logic [7:0] got [$];
        logic [7:0] e, g;
        int lat;
        bit bok;
        for (int c = 0; c < cmds.size(); c++) begin
            send_cmd(cmds[c]);
            collect(got, lat, bok);
            $display("%s: cmd=%0d %0d pixels, first=%h", tag, cmds[c], got.size(), (got.size() > 0) ? got[0] : 8'h00);
            nvec++;
            if (got.size() != 16 || lat !== 0 || !bok) begin
                nerr++;
                $display("FAIL %s_stream%0d: got n=%0d lat=%0d busy_ok=%b required 16/0/1", tag, c, got.size(), lat, bok);
            end
            nvec++;
            if (got.size() == 0 || got[0] !== first[c]) begin
                nerr++;
                $display("FAIL %s_first%0d: got %h required %h", tag, c, (got.size() > 0) ? got[0] : 8'h00, first[c]);
            end
            for (int k = 0; k < 16; k++) begin
                e = exp_q.pop_front();
                g = (got.size() > 0) ? got.pop_front() : 8'h00;
                nvec++;
                if (g !== e) begin nerr++; $display("FAIL %s_c%0d_pix%0d: got %h required %h", tag, c, k, g, e); end
            end
        end
    endtask

    task automatic test_shift();
        run_list_check("shift", '{2, 2, 2, 4, 4, 4}, '{8'h13, 8'h14, 8'h14, 8'h0C, 8'h04, 8'h04});
    endtask

    task automatic test_fit_noop();
        run_list_check("fit", '{7, 5, 0, 6}, '{8'h09, 8'h09, 8'h09, 8'h12});
    endtask

    task automatic test_busy_drop();
        logic [7:0] got [$];
        logic [7:0] e, g;
        int lat;
        bit bok;
        send_cmd(0);
        fork
            collect(got, lat, bok);
            begin
                @(negedge clk);
                @(negedge clk);
                cmd       = 3'd3;
                cmd_valid = 1'b1;
                @(negedge clk);
                cmd_valid = 1'b0;
                cmd       = 3'd0;
            end
        join
        $display("busy_drop: %0d pixels, first=%h", got.size(), (got.size() > 0) ? got[0] : 8'h00);
        nvec++;
        if (got.size() != 16) begin nerr++; $display("FAIL drop_count: got %0d required 16", got.size()); end
        for (int k = 0; k < 16; k++) begin
            e = exp_q.pop_front();
            g = (got.size() > 0) ? got.pop_front() : 8'h00;
            nvec++;
            if (g !== e) begin nerr++; $display("FAIL drop_pix%0d: got %h required %h", k, g, e); end
        end
        @(negedge clk);
        nvec++;
        if (output_valid !== 1'b0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL drop_idle: got valid=%b busy=%b required 0/0", output_valid, busy);
        end
        run_list_check("after_drop", '{0}, '{8'h12});
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        cmd       = 3'd1;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            datain = 8'hFF - 8'(k);
            img[k] = 8'hFF - 8'(k);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        $display("reset_mid_load: busy=%b valid=%b dataout=%h", busy, output_valid, dataout);
        nvec++;
        if (busy !== 1'b0) begin nerr++; $display("FAIL midrst_busy: got %b required 0", busy); end
        nvec++;
        if (output_valid !== 1'b0) begin nerr++; $display("FAIL midrst_valid: got %b required 0", output_valid); end
        nvec++;
        if (dataout !== 8'h00) begin nerr++; $display("FAIL midrst_dataout: got %h required 00", dataout); end
        reset  = 1'b0;
        m_zoom = 0;
        m_row  = 2;
        m_col  = 2;
        run_list_check("partial", '{0}, '{8'hF6});
        test_load();
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd       = 3'd0;
        datain    = 8'h00;
        m_zoom    = 0;
        m_row     = 2;
        m_col     = 2;
        test_reset();
        test_load();
        test_zoom_in();
        test_shift();
        test_fit_noop();
        test_busy_drop();
        test_reset_mid_load();
        nvec++;
        if (exp_q.size() != 0) begin nerr++; $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
